// File: rtl/cn_rst_seq.sv
// Power-on reset and BIST sequencer. It walks the chip from power-good through
// DC-OK, reset hold, BIST clear, BIST run and reset release. Software can
// re-run the sequence from the reset-hold phase.
`timescale 1ns/1ps
module cn_rst_seq #(
  parameter int unsigned DCOK_DLY     = 16,
  parameter int unsigned RST_HOLD_CYC = 32,
  parameter int unsigned CLEAR_CYC    = 4,
  parameter int unsigned BIST_TIMEOUT = 1024,
  parameter int unsigned RELEASE_DLY  = 8,
  parameter int unsigned CNT_W        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pwr_good,
  input  logic bist_complete,
  input  logic sw_rst_req,
  output logic dcok,
  output logic rst_n,
  output logic clear_bist,
  output logic start_bist,
  output logic ready,
  output logic bist_pass,
  output logic bist_fail
);

  // Counters load N-1 on entry so that each timed phase lasts exactly N cycles.
  localparam logic [CNT_W-1:0] DcokLoad  = CNT_W'(DCOK_DLY - 1);
  localparam logic [CNT_W-1:0] HoldLoad  = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] ClearLoad = CNT_W'(CLEAR_CYC - 1);
  localparam logic [CNT_W-1:0] BistLoad  = CNT_W'(BIST_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RelLoad   = CNT_W'(RELEASE_DLY - 1);

  typedef enum logic [2:0] {
    StOff,
    StDcokWait,
    StRstHold,
    StClear,
    StBist,
    StRelease,
    StReady,
    StError
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec;
  logic             cnt_done;
  logic             pg_meta, pg_s;
  logic             pass_d, fail_d;
  logic             dcok_d, rst_n_d, clear_d, start_d, ready_d;

  // Two-flop synchronizer for the asynchronous power-good input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pg_meta <= 1'b0;
      pg_s    <= 1'b0;
    end else begin
      pg_meta <= pwr_good;
      pg_s    <= pg_meta;
    end
  end

  assign cnt_done = (cnt_q == '0);
  assign cnt_dec  = cnt_q - CNT_W'(1);

  // Next-state, phase counter and sticky BIST result logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pass_d  = bist_pass;
    fail_d  = bist_fail;
    if (!pg_s) begin
      // Power loss overrides every other event and drops the BIST result.
      state_d = StOff;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
    end else begin
      unique case (state_q)
        StOff: begin
          state_d = StDcokWait;
          cnt_d   = DcokLoad;
        end
        StDcokWait: begin
          if (cnt_done) begin
            state_d = StRstHold;
            cnt_d   = HoldLoad;
          end else begin
            cnt_d = cnt_dec;
          end
        end
        StRstHold: begin
          if (cnt_done) begin
            state_d = StClear;
            cnt_d   = ClearLoad;
          end else begin
            cnt_d = cnt_dec;
          end
        end
        StClear: begin
          // bist_complete is deliberately not looked at here.
          if (cnt_done) begin
            state_d = StBist;
            cnt_d   = BistLoad;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
          end else begin
            cnt_d = cnt_dec;
          end
        end
        StBist: begin
          // Completion is checked first so it wins over a same-edge timeout.
          if (bist_complete) begin
            state_d = StRelease;
            cnt_d   = RelLoad;
            pass_d  = 1'b1;
          end else if (cnt_done) begin
            state_d = StError;
            fail_d  = 1'b1;
          end else begin
            cnt_d = cnt_dec;
          end
        end
        StRelease: begin
          if (cnt_done) begin
            state_d = StReady;
          end else begin
            cnt_d = cnt_dec;
          end
        end
        StReady, StError: begin
          if (sw_rst_req) begin
            state_d = StRstHold;
            cnt_d   = HoldLoad;
          end
        end
        default: state_d = StOff;
      endcase
    end
  end

  // Output decode from the next state so registered outputs track the state.
  always_comb begin
    dcok_d  = (state_d != StOff) && (state_d != StDcokWait);
    rst_n_d = (state_d == StReady);
    clear_d = (state_d == StClear);
    start_d = (state_d == StBist);
    ready_d = (state_d == StReady);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StOff;
      cnt_q      <= '0;
      dcok       <= 1'b0;
      rst_n      <= 1'b0;
      clear_bist <= 1'b0;
      start_bist <= 1'b0;
      ready      <= 1'b0;
      bist_pass  <= 1'b0;
      bist_fail  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dcok       <= dcok_d;
      rst_n      <= rst_n_d;
      clear_bist <= clear_d;
      start_bist <= start_d;
      ready      <= ready_d;
      bist_pass  <= pass_d;
      bist_fail  <= fail_d;
    end
  end

endmodule

// File: tb/tb_cn_rst_seq.sv
// Directed bench for cn_rst_seq. Times are tracked as edge numbers relative to
// T0, the edge on which the sequencer leaves OFF. The output vector is
// {dcok, rst_n, clear_bist, start_bist, ready, bist_pass, bist_fail}.
`timescale 1ns/1ps
module tb_cn_rst_seq;

  logic clk = 1'b0;
  logic rst, pwr_good, bist_complete, sw_rst_req;
  logic dcok, rst_n, clear_bist, start_bist, ready, bist_pass, bist_fail;
  logic [6:0] obs;
  int tests = 0;
  int fails = 0;
  int cur   = 0;

  cn_rst_seq dut (
    .clk          (clk),
    .rst          (rst),
    .pwr_good     (pwr_good),
    .bist_complete(bist_complete),
    .sw_rst_req   (sw_rst_req),
    .dcok         (dcok),
    .rst_n        (rst_n),
    .clear_bist   (clear_bist),
    .start_bist   (start_bist),
    .ready        (ready),
    .bist_pass    (bist_pass),
    .bist_fail    (bist_fail)
  );

  always #5 clk = ~clk;

  assign obs = {dcok, rst_n, clear_bist, start_bist, ready, bist_pass, bist_fail};

  // Advance to 1ns after relative edge t.
  task automatic adv_to(input int t);
    if (cur < t) begin
      while (cur < t) begin
        @(posedge clk);
        cur++;
      end
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pwr_good = 1'b0; bist_complete = 1'b0; sw_rst_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (obs !== 7'b0000000) begin
      fails++; $display("FAIL reset_vals got=%b exp=%b", obs, 7'b0000000);
    end
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    tests++;
    if (obs !== 7'b0000000) begin
      fails++; $display("FAIL off_no_pg got=%b exp=%b", obs, 7'b0000000);
    end
    // pwr_good rises now: two synchronizer edges, then the FSM leaves OFF.
    pwr_good = 1'b1;
    cur = -3;
  endtask

  task automatic test_nominal();
    adv_to(15);
    tests++;
    if (obs !== 7'b0000000) begin
      fails++; $display("FAIL nom_t15 got=%b exp=%b", obs, 7'b0000000);
    end
    adv_to(16);
    tests++;
    if (obs !== 7'b1000000) begin
      fails++; $display("FAIL nom_dcok_t16 got=%b exp=%b", obs, 7'b1000000);
    end
    // A software request during reset hold must be ignored.
    adv_to(20); sw_rst_req = 1'b1;
    adv_to(21); sw_rst_req = 1'b0;
    adv_to(47);
    tests++;
    if (obs !== 7'b1000000) begin
      fails++; $display("FAIL nom_t47 got=%b exp=%b", obs, 7'b1000000);
    end
    adv_to(48);
    tests++;
    if (obs !== 7'b1010000) begin
      fails++; $display("FAIL nom_clear_t48 got=%b exp=%b", obs, 7'b1010000);
    end
    adv_to(51);
    tests++;
    if (obs !== 7'b1010000) begin
      fails++; $display("FAIL nom_clear_t51 got=%b exp=%b", obs, 7'b1010000);
    end
    adv_to(52);
    tests++;
    if (obs !== 7'b1001000) begin
      fails++; $display("FAIL nom_start_t52 got=%b exp=%b", obs, 7'b1001000);
    end
    adv_to(59);
    tests++;
    if (obs !== 7'b1001000) begin
      fails++; $display("FAIL nom_t59 got=%b exp=%b", obs, 7'b1001000);
    end
    bist_complete = 1'b1;
    adv_to(60);
    bist_complete = 1'b0;
    tests++;
    if (obs !== 7'b1000010) begin
      fails++; $display("FAIL nom_complete_t60 got=%b exp=%b", obs, 7'b1000010);
    end
    adv_to(67);
    tests++;
    if (obs !== 7'b1000010) begin
      fails++; $display("FAIL nom_release_t67 got=%b exp=%b", obs, 7'b1000010);
    end
    adv_to(68);
    tests++;
    if (obs !== 7'b1100110) begin
      fails++; $display("FAIL nom_ready_t68 got=%b exp=%b", obs, 7'b1100110);
    end
  endtask

  // Software re-sequence from READY, with bist_complete stuck high in CLEAR.
  task automatic test_sw_stale();
    sw_rst_req = 1'b1;
    adv_to(69);
    sw_rst_req = 1'b0;
    tests++;
    if (obs !== 7'b1000010) begin
      fails++; $display("FAIL sw_rsthold_t69 got=%b exp=%b", obs, 7'b1000010);
    end
    adv_to(100);
    tests++;
    if (obs !== 7'b1000010) begin
      fails++; $display("FAIL sw_t100 got=%b exp=%b", obs, 7'b1000010);
    end
    bist_complete = 1'b1;
    adv_to(101);
    tests++;
    if (obs !== 7'b1010010) begin
      fails++; $display("FAIL sw_clear_t101 got=%b exp=%b", obs, 7'b1010010);
    end
    adv_to(104);
    tests++;
    if (obs !== 7'b1010010) begin
      fails++; $display("FAIL stale_clear_t104 got=%b exp=%b", obs, 7'b1010010);
    end
    adv_to(105);
    tests++;
    if (obs !== 7'b1001000) begin
      fails++; $display("FAIL stale_bist_entry_t105 got=%b exp=%b", obs, 7'b1001000);
    end
    adv_to(106);
    bist_complete = 1'b0;
    tests++;
    if (obs !== 7'b1000010) begin
      fails++; $display("FAIL stale_exit_t106 got=%b exp=%b", obs, 7'b1000010);
    end
    adv_to(113);
    tests++;
    if (obs !== 7'b1000010) begin
      fails++; $display("FAIL stale_t113 got=%b exp=%b", obs, 7'b1000010);
    end
    adv_to(114);
    tests++;
    if (obs !== 7'b1100110) begin
      fails++; $display("FAIL stale_ready_t114 got=%b exp=%b", obs, 7'b1100110);
    end
  endtask

  task automatic test_async_reset();
    #3;
    rst = 1'b1;
    #1;
    tests++;
    if (obs !== 7'b0000000) begin
      fails++; $display("FAIL async_rst_immediate got=%b exp=%b", obs, 7'b0000000);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cur = -3;
    adv_to(15);
    tests++;
    if (obs !== 7'b0000000) begin
      fails++; $display("FAIL arst_t15 got=%b exp=%b", obs, 7'b0000000);
    end
    adv_to(16);
    tests++;
    if (obs !== 7'b1000000) begin
      fails++; $display("FAIL arst_dcok_t16 got=%b exp=%b", obs, 7'b1000000);
    end
  endtask

  // Continues the sequence begun after the async reset, with no completion.
  task automatic test_timeout();
    adv_to(1075);
    tests++;
    if (obs !== 7'b1001000) begin
      fails++; $display("FAIL to_t1075 got=%b exp=%b", obs, 7'b1001000);
    end
    adv_to(1076);
    tests++;
    if (obs !== 7'b1000001) begin
      fails++; $display("FAIL to_error_t1076 got=%b exp=%b", obs, 7'b1000001);
    end
    adv_to(1100);
    tests++;
    if (obs !== 7'b1000001) begin
      fails++; $display("FAIL to_hold_t1100 got=%b exp=%b", obs, 7'b1000001);
    end
    sw_rst_req = 1'b1;
    adv_to(1101);
    sw_rst_req = 1'b0;
    adv_to(1136);
    tests++;
    if (obs !== 7'b1010001) begin
      fails++; $display("FAIL to_reclear_t1136 got=%b exp=%b", obs, 7'b1010001);
    end
    adv_to(1137);
    tests++;
    if (obs !== 7'b1001000) begin
      fails++; $display("FAIL to_fail_cleared_t1137 got=%b exp=%b", obs, 7'b1001000);
    end
  endtask

  // BIST entered after 1136; timeout expires on edge 1137+1024 = 2161.
  task automatic test_simultaneous();
    adv_to(2160);
    tests++;
    if (obs !== 7'b1001000) begin
      fails++; $display("FAIL sim_t2160 got=%b exp=%b", obs, 7'b1001000);
    end
    bist_complete = 1'b1;
    adv_to(2161);
    bist_complete = 1'b0;
    tests++;
    if (obs !== 7'b1000010) begin
      fails++; $display("FAIL sim_pass_t2161 got=%b exp=%b", obs, 7'b1000010);
    end
    adv_to(2168);
    tests++;
    if (obs !== 7'b1000010) begin
      fails++; $display("FAIL sim_t2168 got=%b exp=%b", obs, 7'b1000010);
    end
    adv_to(2169);
    tests++;
    if (obs !== 7'b1100110) begin
      fails++; $display("FAIL sim_ready_t2169 got=%b exp=%b", obs, 7'b1100110);
    end
  endtask

  task automatic test_power_glitch();
    sw_rst_req = 1'b1;
    adv_to(2170);
    sw_rst_req = 1'b0;
    adv_to(2210);
    tests++;
    if (obs !== 7'b1001000) begin
      fails++; $display("FAIL pg_in_bist_t2210 got=%b exp=%b", obs, 7'b1001000);
    end
    pwr_good = 1'b0;
    adv_to(2212);
    tests++;
    if (obs !== 7'b1001000) begin
      fails++; $display("FAIL pg_latency_t2212 got=%b exp=%b", obs, 7'b1001000);
    end
    adv_to(2213);
    tests++;
    if (obs !== 7'b0000000) begin
      fails++; $display("FAIL pg_off_t2213 got=%b exp=%b", obs, 7'b0000000);
    end
    adv_to(2215);
    pwr_good = 1'b1;
    cur = -3;
    adv_to(15);
    tests++;
    if (obs !== 7'b0000000) begin
      fails++; $display("FAIL pg_restart_t15 got=%b exp=%b", obs, 7'b0000000);
    end
    adv_to(16);
    tests++;
    if (obs !== 7'b1000000) begin
      fails++; $display("FAIL pg_restart_dcok_t16 got=%b exp=%b", obs, 7'b1000000);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_sw_stale();
    test_async_reset();
    test_timeout();
    test_simultaneous();
    test_power_glitch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
